// File: rtl/cpu_do_demux.sv
// -----------------------------------------------------------------------------
// cpu_do_demux
//
// Routes Z80 data-out writes to RAM, LED, IOBYTE, USB TX and S-100 targets.
// The asynchronous WR_n pin is synchronized to pll0_250MHz and its falling
// edge produces one internal write event (wrDet) per WR_n low period. In the
// wrDet cycle the data bus and selects are sampled. Only the highest-priority
// select is acted on: ram > outLED > iobyte > usbTxD > s100.
//
// Build option:
//   CPU_DO_USB_FIFO_EN defined   -> the USB TX buffer is a 4-entry FIFO.
//   CPU_DO_USB_FIFO_EN undefined -> the USB TX buffer is a single holding register.
//
// Parameters:
//   IOBYTE_INIT  reset value of iobyteOut
//
// Ports:
//   pll0_250MHz  in   clock; all state updates on its rising edge
//   reset        in   synchronous, active-high reset
//   cpuDataOut   in   [7:0] Z80 data-out bus
//   cpu_wr_n     in   Z80 WR_n, asynchronous to the clock
//   ram_cs, outLED_cs, iobyteOut_cs, usbTxD_cs, s100Out_cs
//                in   decoded write selects
//   ramaDataIn   out  [7:0] RAM write data, held until the next RAM write
//   ramaWe       out  one-cycle RAM write pulse
//   ledOut       out  [7:0] held LED port value
//   iobyteOut    out  [7:0] held IOBYTE value
//   s100DataOut  out  [7:0] S-100 write data, held until the next S-100 write
//   s100Wr       out  one-cycle S-100 write pulse
//   usbTxData    out  [7:0] oldest byte in the TX buffer
//   usbTxValid   out  TX buffer not empty
//   usbTxReady   in   consumer accepts usbTxData this cycle
//   usbTxFull    out  TX buffer at capacity
//   usbTxOvf     out  sticky: a byte was dropped because the buffer was full
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module cpu_do_demux #(
  parameter logic [7:0] IOBYTE_INIT = 8'h00
) (
  input  logic       pll0_250MHz,
  input  logic       reset,
  input  logic [7:0] cpuDataOut,
  input  logic       cpu_wr_n,
  input  logic       ram_cs,
  input  logic       outLED_cs,
  input  logic       iobyteOut_cs,
  input  logic       usbTxD_cs,
  input  logic       s100Out_cs,
  output logic [7:0] ramaDataIn,
  output logic       ramaWe,
  output logic [7:0] ledOut,
  output logic [7:0] iobyteOut,
  output logic [7:0] s100DataOut,
  output logic       s100Wr,
  output logic [7:0] usbTxData,
  output logic       usbTxValid,
  input  logic       usbTxReady,
  output logic       usbTxFull,
  output logic       usbTxOvf
);

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_RAM,
    ACT_LED,
    ACT_IOBYTE,
    ACT_USB,
    ACT_S100
  } action_t;

  // Synchronizer stages plus one delay stage for edge detection.
  // They idle high, matching an inactive WR_n.
  logic    wrSync1;
  logic    wrSync2;
  logic    wrSyncDly;
  logic    wrDet;
  action_t action;

  logic    usbPush;   // write event addressed to the USB TX buffer
  logic    usbPop;    // consumer takes the head byte this cycle
  logic    usbAccept; // push actually lands in the buffer

  // One event per falling edge of the synchronized WR_n. A long low period
  // cannot retrigger, because wrSyncDly follows wrSync2 low.
  assign wrDet = wrSyncDly & ~wrSync2;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    action = ACT_NONE;
    if (wrDet) begin
      if (ram_cs)            action = ACT_RAM;
      else if (outLED_cs)    action = ACT_LED;
      else if (iobyteOut_cs) action = ACT_IOBYTE;
      else if (usbTxD_cs)    action = ACT_USB;
      else if (s100Out_cs)   action = ACT_S100;
    end
  end

  assign usbPush   = (action == ACT_USB);
  assign usbPop    = usbTxValid & usbTxReady;
  // A pop in the same cycle frees the slot, so a push into a full buffer
  // still succeeds when the head is being consumed.
  assign usbAccept = usbPush & (~usbTxFull | usbPop);

  always_ff @(posedge pll0_250MHz) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      wrSync1     <= 1'b1;
      wrSync2     <= 1'b1;
      wrSyncDly   <= 1'b1;
      ramaWe      <= 1'b0;
      s100Wr      <= 1'b0;
      ramaDataIn  <= 8'h00;
      s100DataOut <= 8'h00;
      ledOut      <= 8'h00;
      iobyteOut   <= IOBYTE_INIT;
      usbTxOvf    <= 1'b0;
    end else begin
      wrSync1   <= cpu_wr_n;
      wrSync2   <= wrSync1;
      wrSyncDly <= wrSync2;

      // Strobes are high only in the cycle after the write event.
      ramaWe <= (action == ACT_RAM);
      s100Wr <= (action == ACT_S100);

      if (action == ACT_RAM)    ramaDataIn  <= cpuDataOut;
      if (action == ACT_S100)   s100DataOut <= cpuDataOut;
      if (action == ACT_LED)    ledOut      <= cpuDataOut;
      if (action == ACT_IOBYTE) iobyteOut   <= cpuDataOut;

      if (usbPush && usbTxFull && !usbPop) usbTxOvf <= 1'b1;
    end
  end

`ifdef CPU_DO_USB_FIFO_EN
  // 4-entry circular buffer. The 2-bit pointers wrap naturally. The 3-bit
  // count tells full (4) apart from empty (0).
  logic [7:0] fifoMem [4];
  logic [1:0] wrPtr;
  logic [1:0] rdPtr;
  logic [2:0] fifoCount;

  // NOTE: the storage array is deliberately not reset. Validity comes from
  // fifoCount, and the output is forced to zero while the buffer is empty.
  always_ff @(posedge pll0_250MHz) begin
    if (usbAccept && !reset) fifoMem[wrPtr] <= cpuDataOut;
  end

  always_ff @(posedge pll0_250MHz) begin
    if (reset) begin
      wrPtr     <= 2'd0;
      rdPtr     <= 2'd0;
      fifoCount <= 3'd0;
    end else begin
      if (usbAccept) wrPtr <= wrPtr + 2'd1;
      if (usbPop)    rdPtr <= rdPtr + 2'd1;
      case ({usbAccept, usbPop})
        2'b10:   fifoCount <= fifoCount + 3'd1;
        2'b01:   fifoCount <= fifoCount - 3'd1;
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  assign usbTxValid = (fifoCount != 3'd0);
  assign usbTxFull  = (fifoCount == 3'd4);
  assign usbTxData  = usbTxValid ? fifoMem[rdPtr] : 8'h00;
`else
  // Single holding register: it is full whenever it holds a byte.
  logic [7:0] holdData;
  logic       holdValid;

  always_ff @(posedge pll0_250MHz) begin
    if (reset) begin
      holdData  <= 8'h00;
      holdValid <= 1'b0;
    end else if (usbAccept) begin
      holdData  <= cpuDataOut;
      holdValid <= 1'b1;
    end else if (usbPop) begin
      holdValid <= 1'b0;
    end
  end

  assign usbTxValid = holdValid;
  assign usbTxFull  = holdValid;
  assign usbTxData  = holdData;
`endif

endmodule

// File: tb/tb_cpu_do_demux.sv
// -----------------------------------------------------------------------------
// tb_cpu_do_demux
//
// Self-checking bench for cpu_do_demux. The reference model keeps the USB TX
// buffer as a queue bounded by the buffer capacity. It also keeps the expected
// held register values and the expected strobes. The bench advances the model
// one clock at a time, in step with the stimulus.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_cpu_do_demux;

  localparam logic [7:0] IOB_INIT = 8'h5A;
`ifdef CPU_DO_USB_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cpuDataOut;
  logic       cpu_wr_n;
  logic       ram_cs, outLED_cs, iobyteOut_cs, usbTxD_cs, s100Out_cs;
  logic [7:0] ramaDataIn;
  logic       ramaWe;
  logic [7:0] ledOut;
  logic [7:0] iobyteOut;
  logic [7:0] s100DataOut;
  logic       s100Wr;
  logic [7:0] usbTxData;
  logic       usbTxValid;
  logic       usbTxReady;
  logic       usbTxFull;
  logic       usbTxOvf;

  cpu_do_demux #(.IOBYTE_INIT(IOB_INIT)) dut (
    .pll0_250MHz  (clk),
    .reset        (reset),
    .cpuDataOut   (cpuDataOut),
    .cpu_wr_n     (cpu_wr_n),
    .ram_cs       (ram_cs),
    .outLED_cs    (outLED_cs),
    .iobyteOut_cs (iobyteOut_cs),
    .usbTxD_cs    (usbTxD_cs),
    .s100Out_cs   (s100Out_cs),
    .ramaDataIn   (ramaDataIn),
    .ramaWe       (ramaWe),
    .ledOut       (ledOut),
    .iobyteOut    (iobyteOut),
    .s100DataOut  (s100DataOut),
    .s100Wr       (s100Wr),
    .usbTxData    (usbTxData),
    .usbTxValid   (usbTxValid),
    .usbTxReady   (usbTxReady),
    .usbTxFull    (usbTxFull),
    .usbTxOvf     (usbTxOvf)
  );

  always #2 clk = ~clk;

  // Reference model state.
  logic [7:0] txQ[$];
  logic [7:0] expLed, expIob, expRamData, expS100Data;
  bit         expOvf;
  bit         randReady;
  int         ramPulses, s100Pulses, popCount;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    txQ.delete();
    expLed      = 8'h00;
    expIob      = IOB_INIT;
    expRamData  = 8'h00;
    expS100Data = 8'h00;
    expOvf      = 1'b0;
  endtask

  // Advances one clock. The call starts at a falling edge and ends at the
  // next falling edge. With act set, this clock's rising edge is the one at
  // which the write event takes effect.
  task automatic tick(input bit act, input logic [4:0] sel, input logic [7:0] d);
    bit expRam  = 1'b0;
    bit expS100 = 1'b0;
    if (randReady) usbTxReady = 1'($urandom_range(0, 1));
    if (txQ.size() != 0 && usbTxReady) begin
      check("usbTxData at pop", usbTxData, txQ[0]);
      void'(txQ.pop_front());
      popCount++;
    end
    if (act) begin
      // Bits are {ram, led, iobyte, usb, s100}, highest priority first.
      if (sel[4]) begin
        expRam = 1'b1;
        expRamData = d;
      end else if (sel[3]) begin
        expLed = d;
      end else if (sel[2]) begin
        expIob = d;
      end else if (sel[1]) begin
        if (txQ.size() < CAP) txQ.push_back(d);
        else expOvf = 1'b1;
      end else if (sel[0]) begin
        expS100 = 1'b1;
        expS100Data = d;
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (ramaWe) ramPulses++;
    if (s100Wr) s100Pulses++;
    check("ramaWe", ramaWe, expRam);
    check("ramaDataIn", ramaDataIn, expRamData);
    check("s100Wr", s100Wr, expS100);
    check("s100DataOut", s100DataOut, expS100Data);
    check("ledOut", ledOut, expLed);
    check("iobyteOut", iobyteOut, expIob);
    check("usbTxValid", usbTxValid, (txQ.size() != 0));
    check("usbTxFull", usbTxFull, (txQ.size() == CAP));
    check("usbTxOvf", usbTxOvf, expOvf);
    if (txQ.size() != 0) check("usbTxData head", usbTxData, txQ[0]);
  endtask

  // One complete WR_n cycle. The write event takes effect on the third rising
  // edge after the pin falls: two synchronizer stages plus the edge detector.
  // After that edge the bus changes, which shows that the data was latched.
  task automatic cpuWrite(input logic [4:0] sel, input logic [7:0] d,
                          input int lowCycles, input int highCycles);
    cpuDataOut = d;
    {ram_cs, outLED_cs, iobyteOut_cs, usbTxD_cs, s100Out_cs} = sel;
    cpu_wr_n = 1'b0;
    for (int i = 1; i <= lowCycles; i++) begin
      tick(i == 3, sel, d);
      if (i == 3) cpuDataOut = ~d;
    end
    cpu_wr_n = 1'b1;
    for (int i = 0; i < highCycles; i++) tick(1'b0, sel, d);
    {ram_cs, outLED_cs, iobyteOut_cs, usbTxD_cs, s100Out_cs} = 5'b0;
  endtask

  // Asserts reset for the given number of rising edges. Checks the state at
  // the first falling edge after the first reset edge, then releases reset.
  task automatic resetDut(input int cycles);
    reset = 1'b1;
    cpu_wr_n = 1'b1;
    {ram_cs, outLED_cs, iobyteOut_cs, usbTxD_cs, s100Out_cs} = 5'b0;
    modelReset();
    @(posedge clk);
    @(negedge clk);
    check("rst usbTxValid", usbTxValid, 8'h00);
    check("rst usbTxOvf", usbTxOvf, 8'h00);
    check("rst usbTxFull", usbTxFull, 8'h00);
    check("rst usbTxData", usbTxData, 8'h00);
    check("rst iobyteOut", iobyteOut, IOB_INIT);
    check("rst ledOut", ledOut, 8'h00);
    check("rst ramaWe", ramaWe, 8'h00);
    check("rst s100Wr", s100Wr, 8'h00);
    check("rst ramaDataIn", ramaDataIn, 8'h00);
    check("rst s100DataOut", s100DataOut, 8'h00);
    for (int i = 1; i < cycles; i++) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    cpuDataOut = 8'h00;
    cpu_wr_n = 1'b1;
    {ram_cs, outLED_cs, iobyteOut_cs, usbTxD_cs, s100Out_cs} = 5'b0;
    usbTxReady = 1'b0;
    randReady = 1'b0;
    ramPulses = 0;
    s100Pulses = 0;
    popCount = 0;
    @(negedge clk);
    resetDut(3);

    // LED write: the value must appear within 4 clocks and cause no strobes.
    cpuWrite(5'b01000, 8'hA5, 4, 3);
    check("led A5", ledOut, 8'hA5);
    check("led no ram pulse", 8'(ramPulses), 8'd0);
    check("led no s100 pulse", 8'(s100Pulses), 8'd0);

    // A long WR_n low period must produce exactly one RAM strobe.
    ramPulses = 0;
    cpuWrite(5'b10000, 8'h3C, 20, 3);
    check("long low one ramaWe", 8'(ramPulses), 8'd1);
    check("long low ramaDataIn", ramaDataIn, 8'h3C);

    // RAM select outranks LED select.
    ramPulses = 0;
    cpuWrite(5'b11000, 8'h11, 4, 3);
    check("prio ramaWe once", 8'(ramPulses), 8'd1);
    check("prio ledOut unchanged", ledOut, 8'hA5);

    // IOBYTE write, S-100 write, and a write with no select.
    cpuWrite(5'b00100, 8'hC3, 3, 3);
    s100Pulses = 0;
    cpuWrite(5'b00001, 8'h96, 5, 3);
    check("s100 one pulse", 8'(s100Pulses), 8'd1);
    cpuWrite(5'b00000, 8'hFF, 4, 3);

`ifdef CPU_DO_USB_FIFO_EN
    // Fill the FIFO, overflow it, then drain it.
    usbTxReady = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cpuWrite(5'b00010, 8'(i), 4, 3);
      if (i == 4) check("fifo full after 4", usbTxFull, 8'h01);
      if (i == 4) check("fifo no ovf after 4", usbTxOvf, 8'h00);
    end
    check("fifo ovf after 5", usbTxOvf, 8'h01);
    popCount = 0;
    usbTxReady = 1'b1;
    for (int i = 0; i < 10; i++) tick(1'b0, 5'b0, 8'h00);
    check("fifo drained count", 8'(popCount), 8'd4);
    check("fifo valid drops", usbTxValid, 8'h00);
    check("fifo ovf sticky", usbTxOvf, 8'h01);
`else
    // The holding register keeps the first byte; the second byte overflows.
    usbTxReady = 1'b0;
    cpuWrite(5'b00010, 8'h7E, 4, 3);
    cpuWrite(5'b00010, 8'h7F, 4, 3);
    check("hold data 7E", usbTxData, 8'h7E);
    check("hold ovf", usbTxOvf, 8'h01);
    usbTxReady = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0, 5'b0, 8'h00);
    check("hold valid drops", usbTxValid, 8'h00);
    check("hold ovf sticky", usbTxOvf, 8'h01);
`endif

    // Reset with TX bytes buffered and IOBYTE changed.
    resetDut(2);
    usbTxReady = 1'b0;
    cpuWrite(5'b00100, 8'h42, 4, 3);
    cpuWrite(5'b00010, 8'hD1, 4, 3);
    cpuWrite(5'b00010, 8'hD2, 4, 3);
    check("pre-reset iobyte", iobyteOut, 8'h42);
    check("pre-reset valid", usbTxValid, 8'h01);
    resetDut(1);
    check("post-reset valid", usbTxValid, 8'h00);
    check("post-reset iobyte", iobyteOut, IOB_INIT);

    // Random writes with random consumer back-pressure.
    randReady = 1'b1;
    for (int n = 0; n < 80; n++) begin
      logic [4:0] sel;
      sel = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) sel = 5'b00010;
      cpuWrite(sel, 8'($urandom), int'($urandom_range(3, 8)), int'($urandom_range(3, 5)));
    end
    randReady = 1'b0;
    usbTxReady = 1'b1;
    for (int i = 0; i < 8; i++) tick(1'b0, 5'b0, 8'h00);
    check("final drained", usbTxValid, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_do_demux.md
CPU_DO_DEMUX -- requirements
Module: cpu_do_demux

Interface
REQ-001 SHALL have parameter IOBYTE_INIT, default 8'h00, reset value of iobyteOut.
REQ-002 SHALL have port pll0_250MHz, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port cpuDataOut, input, 8 bits: Z80 data-out bus.
REQ-005 SHALL have port cpu_wr_n, input, 1 bit: Z80 WR_n, asynchronous to the clock.
REQ-006 SHALL have ports ram_cs, outLED_cs, iobyteOut_cs, usbTxD_cs and s100Out_cs, each input, 1 bit: decoded write selects.
REQ-007 SHALL have port ramaDataIn, output, 8 bits, and port ramaWe, output, 1 bit: RAM write data and write pulse.
REQ-008 SHALL have port ledOut, output, 8 bits: held LED port value.
REQ-009 SHALL have port iobyteOut, output, 8 bits: held IOBYTE value.
REQ-010 SHALL have port s100DataOut, output, 8 bits, and port s100Wr, output, 1 bit: S-100 bus write data and write pulse.
REQ-011 SHALL have ports usbTxData, output, 8 bits; usbTxValid, output, 1 bit; usbTxReady, input, 1 bit: USB TX valid/ready handshake.
REQ-012 SHALL have ports usbTxFull, output, 1 bit, and usbTxOvf, output, 1 bit: TX buffer full indicator and sticky overflow flag.

Function
REQ-013 SHALL pass cpu_wr_n through a 2-flop synchronizer, then detect a 1->0 transition of the synchronized signal as a one-cycle internal event wrDet.
REQ-014 SHALL, in the wrDet cycle, sample cpuDataOut and all selects, and act on only the highest-priority asserted select: ram_cs > outLED_cs > iobyteOut_cs > usbTxD_cs > s100Out_cs.
REQ-015 SHALL apply no action when no select is asserted in the wrDet cycle.
REQ-016 SHALL, for ram_cs and s100Out_cs, register the sampled data onto ramaDataIn or s100DataOut and assert ramaWe or s100Wr for exactly one cycle, the cycle after wrDet; the data outputs hold until the next write of that type.
REQ-017 SHALL load ledOut or iobyteOut with the sampled data on the edge ending the wrDet cycle.
REQ-018 SHALL produce exactly one action per WR_n low period, regardless of how long WR_n stays low.
REQ-019 SHALL, for usbTxD_cs, push the sampled byte into the TX buffer; usbTxValid = buffer not empty; usbTxData = oldest entry; a pop occurs on any cycle with usbTxValid & usbTxReady.
REQ-020 SHALL, when a push and a pop coincide, perform both, including when the buffer is full.
REQ-021 SHALL, on a push while full without a coincident pop, discard the byte, leave contents unchanged and set usbTxOvf; usbTxOvf clears only on reset.
REQ-022 SHALL drive usbTxFull combinationally from buffer occupancy equal to capacity.

Reset
REQ-023 SHALL, while reset is high, clear the synchronizer to the idle (high) state, clear ramaWe, s100Wr, usbTxValid and usbTxOvf, clear ramaDataIn, s100DataOut, ledOut and usbTxData to 8'h00, set iobyteOut to IOBYTE_INIT, and empty the TX buffer.
REQ-024 SHALL, when reset is asserted mid-operation, abandon any pending strobe and discard all buffered TX bytes; no strobe occurs for a write detected in a reset cycle.

Configuration
REQ-025 SHALL, with macro CPU_DO_USB_FIFO_EN defined, implement the TX buffer as a 4-entry FIFO with 2-bit wrapping pointers and a 3-bit count.
REQ-026 SHALL, without CPU_DO_USB_FIFO_EN, implement the TX buffer as a single holding register with usbTxFull = usbTxValid.

Verification
REQ-027 SHALL cover: reset, then WR_n low with outLED_cs=1 and data 8'hA5 -> ledOut=8'hA5 within 4 clocks of the pin edge; ramaWe and s100Wr remain 0.
REQ-028 SHALL cover: WR_n low for 20 cycles with ram_cs=1 and data 8'h3C -> exactly one ramaWe pulse with ramaDataIn=8'h3C.
REQ-029 SHALL cover: ram_cs=1 and outLED_cs=1 together with data 8'h11 -> ramaWe pulses once; ledOut unchanged.
REQ-030 SHALL cover, with the FIFO enabled: 5 USB writes 8'h01..8'h05 with usbTxReady=0 -> usbTxFull=1 after the 4th write, usbTxOvf=1 after the 5th; then usbTxReady=1 -> 01,02,03,04 are output in order and usbTxValid drops.
REQ-031 SHALL cover, with the FIFO disabled: writes 8'h7E then 8'h7F with usbTxReady=0 -> usbTxData=8'h7E and usbTxOvf=1.
REQ-032 SHALL cover: reset asserted while 2 TX bytes are buffered -> usbTxValid=0 and iobyteOut=IOBYTE_INIT on the next cycle.
